// File: rtl/qk_score_buffer_pkg.sv
// Shared types and constants for the QK score ping-pong buffer.
// Bank lifecycle enum plus Q8.8 -> Q4.4 fixed-point framing.
package qk_score_buffer_pkg;

    localparam int SASA_Q_IN_FRAC  = 8;
    localparam int SASA_Q_OUT_FRAC = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_e;

    // A bank takes producer writes until it holds a complete matrix.
    function automatic logic bank_writable(input bank_state_e st);
        return (st == EMPTY) || (st == FILLING);
    endfunction

endpackage

// File: rtl/qk_quantizer.sv
// Purpose: signed fixed-point requantiser, round half away from zero, saturating.
// Latency: combinational. Backpressure: none (pure function of the input).
module qk_quantizer
    import qk_score_buffer_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int IN_FRAC  = SASA_Q_IN_FRAC,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = SASA_Q_OUT_FRAC
) (
    input  logic [IN_W-1:0]  score,
    output logic [OUT_W-1:0] quant
);

    localparam int SH = IN_FRAC - OUT_FRAC;

    // Negative inputs add one less so that an exact half rounds towards -inf.
    localparam logic signed [IN_W:0] HALF_POS = (IN_W+1)'(2 ** (SH - 1));
    localparam logic signed [IN_W:0] HALF_NEG = (IN_W+1)'(2 ** (SH - 1) - 1);
    localparam logic signed [IN_W:0] QMAX     = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] QMIN     = ~QMAX;

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] biased;
    logic signed [IN_W:0] shifted;

    always_comb begin
        ext     = {score[IN_W-1], score};
        biased  = ext + (score[IN_W-1] ? HALF_NEG : HALF_POS);
        shifted = biased >>> SH;
        if (shifted > QMAX) begin
            quant = QMAX[OUT_W-1:0];
        end else if (shifted < QMIN) begin
            quant = QMIN[OUT_W-1:0];
        end else begin
            quant = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/qk_score_buffer.sv
// Purpose: two-bank ping-pong score store between the QK matmul and softmax, with per-row max.
// Latency: last write to data_ready is 2 cycles; reads are combinational from the read bank.
// Backpressure: wr_ready drops while the write bank is FULL or READING; finish frees a bank.
module qk_score_buffer
    import qk_score_buffer_pkg::*;
#(
    parameter int S_MATRIX = 16,
    parameter int IN_W     = 16,
    parameter int IN_FRAC  = SASA_Q_IN_FRAC,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = SASA_Q_OUT_FRAC
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [IN_W-1:0]             wr_data,
    output logic                        data_ready,
    input  logic                        data_req,
    input  logic [$clog2(S_MATRIX)-1:0] data_addr_x,
    input  logic [$clog2(S_MATRIX)-1:0] data_addr_y,
    output logic [OUT_W-1:0]            data,
    output logic [OUT_W-1:0]            row_max,
    input  logic                        finish
);

    localparam int AW    = $clog2(S_MATRIX);
    localparam int CW    = 2 * AW;
    localparam int DEPTH = S_MATRIX * S_MATRIX;

    bank_state_e bank_st  [2];
    bank_state_e bank_nxt [2];
    logic        wr_ptr;
    logic        wr_ptr_nxt;
    logic        rd_ptr;
    logic        rd_ptr_nxt;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] wr_cnt_nxt;

    logic [OUT_W-1:0] q;
    logic             accept;
    logic             last;
    logic             release_bank;
    logic [AW-1:0]    wr_row;
    logic [AW-1:0]    wr_col;

    logic [OUT_W-1:0] mem  [2][S_MATRIX][S_MATRIX];
    logic [OUT_W-1:0] rmax [2][S_MATRIX];

    qk_quantizer #(
        .IN_W     (IN_W),
        .IN_FRAC  (IN_FRAC),
        .OUT_W    (OUT_W),
        .OUT_FRAC (OUT_FRAC)
    ) u_quant (
        .score (wr_data),
        .quant (q)
    );

    assign wr_ready     = bank_writable(bank_st[wr_ptr]);
    assign data_ready   = (bank_st[rd_ptr] == READING);
    assign accept       = reset && wr_valid && wr_ready;
    assign last         = (wr_cnt == CW'(DEPTH - 1));
    assign release_bank = finish && data_ready;
    assign wr_row       = wr_cnt[CW-1:AW];
    assign wr_col       = wr_cnt[AW-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_cnt     <= '0;
        end else begin
            bank_st <= bank_nxt;
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            wr_cnt  <= wr_cnt_nxt;
        end
    end

    // Write and read sides never touch the same bank in one cycle: the write
    // bank is EMPTY/FILLING, while finish and promotion act on FULL/READING.
    always_comb begin
        bank_nxt   = bank_st;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        wr_cnt_nxt = wr_cnt;

        if (accept) begin
            wr_cnt_nxt = wr_cnt + 1'b1;
            if (last) begin
                bank_nxt[wr_ptr] = FULL;
                wr_ptr_nxt       = ~wr_ptr;
            end else begin
                bank_nxt[wr_ptr] = FILLING;
            end
        end

        if (release_bank) begin
            bank_nxt[rd_ptr] = EMPTY;
            rd_ptr_nxt       = ~rd_ptr;
        end else if (bank_st[rd_ptr] == FULL) begin
            bank_nxt[rd_ptr] = READING;
        end
    end

    // Column 0 seeds the row max so stale values from an earlier matrix never leak in.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr][wr_row][wr_col] <= q;
            if ((wr_col == '0) || ($signed(q) > $signed(rmax[wr_ptr][wr_row]))) begin
                rmax[wr_ptr][wr_row] <= q;
            end
        end
    end

    always_comb begin
        data    = '0;
        row_max = '0;
        if (data_req && data_ready) begin
            data    = mem[rd_ptr][data_addr_y][data_addr_x];
            row_max = rmax[rd_ptr][data_addr_y];
        end
    end

endmodule

// File: tb/tb_qk_score_buffer.sv
// Directed-sequence bench with randomized score streams checked against an
// integer-arithmetic reference image of each bank.
module tb_qk_score_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic        data_ready;
    logic        data_req = 1'b0;
    logic [3:0]  ax = '0;
    logic [3:0]  ay = '0;
    logic [7:0]  data;
    logic [7:0]  row_max;
    logic        finish = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] stim [256];
    logic [7:0]  img  [2][256];
    int          m_wr_bank = 0;

    always #5 clk = ~clk;

    qk_score_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .data_ready  (data_ready),
        .data_req    (data_req),
        .data_addr_x (ax),
        .data_addr_y (ay),
        .data        (data),
        .row_max     (row_max),
        .finish      (finish)
    );

    function automatic logic [7:0] quant_ref(input logic [15:0] raw);
        int v, a, m, r;
        v = int'($signed(raw));
        a = (v < 0) ? -v : v;
        m = (a + 8) / 16;
        r = (v < 0) ? -m : m;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return 8'(r);
    endfunction

    function automatic logic [7:0] row_max_ref(input int b, input int y);
        int best, val;
        best = -1000;
        for (int x = 0; x < 16; x++) begin
            val = int'($signed(img[b][16*y + x]));
            if (val > best) best = val;
        end
        return 8'(best);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_stim();
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 1) == 1) stim[i] = 16'($urandom);
            else                           stim[i] = 16'($urandom_range(0, 4095) - 2048);
        end
    endtask

    task automatic write_stream(input int n, input bit fin_last);
        int waited;
        for (int i = 0; i < n; i++) begin
            waited   = 0;
            wr_valid = 1'b1;
            wr_data  = stim[i];
            while (!wr_ready && waited < 2000) begin
                tick();
                waited++;
            end
            if (!wr_ready) begin
                check("wr_ready_timeout", 32'(wr_ready), 32'd1);
                wr_valid = 1'b0;
                return;
            end
            if (fin_last && i == n - 1) finish = 1'b1;
            img[m_wr_bank][i] = quant_ref(stim[i]);
            tick();
            finish = 1'b0;
        end
        wr_valid = 1'b0;
        if (n == 256) m_wr_bank ^= 1;
    endtask

    task automatic read_at(input int x, input int y, output logic [7:0] d, output logic [7:0] m);
        data_req = 1'b1;
        ax = 4'(x);
        ay = 4'(y);
        #2;
        d = data;
        m = row_max;
        data_req = 1'b0;
        tick();
    endtask

    // n_rand == 0 sweeps the whole bank, otherwise n_rand random addresses.
    task automatic check_bank(input int b, input int n_rand);
        logic [7:0] d, m;
        int x, y, total;
        total = (n_rand == 0) ? 256 : n_rand;
        for (int k = 0; k < total; k++) begin
            if (n_rand == 0) begin
                x = k % 16;
                y = k / 16;
            end else begin
                x = int'($urandom_range(0, 15));
                y = int'($urandom_range(0, 15));
            end
            read_at(x, y, d, m);
            check($sformatf("data[%0d][%0d]", y, x), 32'(d), 32'(img[b][16*y + x]));
            if (x == 0 || n_rand != 0)
                check($sformatf("row_max[%0d]", y), 32'(m), 32'(row_max_ref(b, y)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, observed hang expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d, m;

        // Reset state
        reset = 1'b0;
        data_req = 1'b1;
        repeat (3) tick();
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_row_max", 32'(row_max), 32'd0);
        data_req = 1'b0;
        reset = 1'b1;
        tick();

        // Ramp k*16: quantises to k, saturating at 127 from row 8 on
        for (int k = 0; k < 256; k++) stim[k] = 16'(k * 16);
        write_stream(256, 1'b0);
        check("ramp_lat1", 32'(data_ready), 32'd0);
        tick();
        check("ramp_lat2", 32'(data_ready), 32'd1);
        check_bank(0, 0);

        // Second bank with directed quantiser cases and a negative-only row
        rand_stim();
        stim[0] = 16'h0180;
        stim[1] = 16'h0008;
        stim[2] = 16'hFFF8;
        stim[3] = 16'h0900;
        stim[4] = 16'hF700;
        for (int x = 0; x < 16; x++) stim[16 + x] = 16'(-256 + 16 * x);
        write_stream(256, 1'b0);
        check("both_full_wr_ready", 32'(wr_ready), 32'd0);
        check("both_full_data_ready", 32'(data_ready), 32'd1);
        read_at(0, 0, d, m);
        check("bank0_still_read", 32'(d), 32'(img[0][0]));
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("fin_data_ready_drop", 32'(data_ready), 32'd0);
        check("fin_wr_ready_rise", 32'(wr_ready), 32'd1);
        tick();
        check("fin_data_ready_back", 32'(data_ready), 32'd1);
        read_at(0, 0, d, m);
        check("q_0180", 32'(d), 32'h18);
        read_at(1, 0, d, m);
        check("q_0008", 32'(d), 32'h01);
        read_at(2, 0, d, m);
        check("q_FFF8", 32'(d), 32'hFF);
        read_at(3, 0, d, m);
        check("q_0900", 32'(d), 32'h7F);
        read_at(4, 0, d, m);
        check("q_F700", 32'(d), 32'h80);
        read_at(5, 1, d, m);
        check("neg_row_max", 32'(m), 32'hFF);
        check_bank(1, 40);

        // Finish coincides with the 256th write into the other bank
        rand_stim();
        write_stream(256, 1'b1);
        check("coinc_drop", 32'(data_ready), 32'd0);
        tick();
        check("coinc_back", 32'(data_ready), 32'd1);
        check_bank(0, 0);

        // Reset mid-stream, then a clean refill
        rand_stim();
        write_stream(100, 1'b0);
        reset = 1'b0;
        data_req = 1'b1;
        ax = 4'($urandom_range(0, 15));
        ay = 4'($urandom_range(0, 15));
        tick();
        check("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
        check("mid_rst_data_ready", 32'(data_ready), 32'd0);
        check("mid_rst_data", 32'(data), 32'd0);
        check("mid_rst_row_max", 32'(row_max), 32'd0);
        data_req = 1'b0;
        reset = 1'b1;
        m_wr_bank = 0;
        tick();
        rand_stim();
        write_stream(256, 1'b0);
        check("post_rst_lat1", 32'(data_ready), 32'd0);
        tick();
        check("post_rst_lat2", 32'(data_ready), 32'd1);
        check_bank(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
